scancode_tx: RTL and testbench
==============================

Name: scancode_tx

Overview:
Key-event to PS/2 Set-2 byte-stream encoder. It is the transmit-side counterpart of the keyboard byte decoder. It accepts key events, each a 9-bit key code plus a make or break pulse, and queues them in a small FIFO. It then emits the matching scan-code byte sequence (E0 / F0 prefixes followed by the code) over a valid/ready byte interface. Typical sinks are a PS/2 device-side serializer or a keyboard model used in simulation.

Parameters:
FIFO_DEPTH, 4, number of queued key events; must be a power of 2, minimum 2.
GAP_CYCLES, 2, idle cycles with dout_valid low after the last byte of each sequence; 0 means no gap.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
keyCode  in  9  [8] = extended flag, [7:0] = scan code; sampled when make or brakk is high.
make  in  1  one-cycle request to enqueue a key-press event.
brakk  in  1  one-cycle request to enqueue a key-release event.
ev_ready  out  1  FIFO not full; combinational, equal to !full.
dout  out  8  byte to the serializer; registered.
dout_valid  out  1  dout holds a valid byte; registered.
dout_ready  in  1  sink accepts the byte; a transfer occurs on any edge where dout_valid && dout_ready.
busy  out  1  high when the sequencer is not IDLE or the FIFO is non-empty.
overflow  out  1  one-cycle pulse: a valid event was dropped because the FIFO was full.
bad_code  out  1  one-cycle pulse: an event was rejected as malformed.

Behaviour:
- Reset values: dout=8'h00, dout_valid=0, busy=0, overflow=0, bad_code=0, FIFO empty (so ev_ready=1), FSM in IDLE.
- Event validity: a cycle with make^brakk = 1 and keyCode[7:0] in 1..131 is a valid event.
- Rejections:
  - make && brakk both high → no enqueue, bad_code pulses on the next cycle.
  - A code of 0 or greater than 131 → no enqueue, bad_code pulses on the next cycle.
  - A valid event while ev_ready=0 → dropped, overflow pulses on the next cycle. FIFO contents are unchanged.
- FIFO entry is 10 bits: {is_break, ext, code}. Entries are written on the accepting edge.
- Push and pop in the same cycle are both legal. When the FIFO is full, a push alongside a pop is still rejected, because ev_ready is !full sampled before the edge.
- Byte sequences (in order):
  - make, normal: code
  - make, ext: E0, code
  - break, normal: F0, code
  - break, ext: E0, F0, code
- FSM states: IDLE, SEND_E0, SEND_F0, SEND_CODE, GAP.
- IDLE: if the FIFO is non-empty, pop the head into a holding register and go to the first state of its sequence. dout and dout_valid=1 are loaded on that same edge.
- SEND_x: hold dout and dout_valid stable until a transfer occurs. On the transfer, load the next byte and its state, or go to GAP after the code byte.
  - When GAP_CYCLES=0, go directly to IDLE instead of GAP.
  - When GAP_CYCLES=0 and the FIFO is non-empty, pop immediately and load the next sequence's first byte with no bubble.
- GAP: dout_valid=0 for GAP_CYCLES cycles (down-counter), then go to IDLE.
- Latency: with an empty FIFO in IDLE, a valid event sampled at edge N gives dout_valid=1 with the first byte after edge N+1.
- dout must not change while dout_valid=1 and dout_ready=0.
- dout_ready while dout_valid=0 is ignored.
- Reset mid-sequence: all state clears immediately (asynchronous); dout_valid drops without completing the sequence, and the FIFO is flushed.
- Invalid FSM encoding returns to IDLE with dout_valid=0.

Test Plan:
1. Normal make: make with keyCode=9'h01C, dout_ready=1 → dout_valid high for exactly one transfer with dout=1C, then GAP_CYCLES low cycles, busy returns to 0.
2. Extended break: brakk with keyCode=9'h175, dout_ready=1 → transfers E0, F0, 75 on consecutive edges; dout_valid is first high 2 edges after the request.
3. Backpressure: extended make keyCode=9'h16B with dout_ready=0 for 5 cycles → dout=E0 held stable with valid=1 throughout; after release, transfers are E0 then 6B.
4. Overflow (FIFO_DEPTH=4): dout_ready=0 and 6 back-to-back make events codes 01..06 → 4 events enqueued; the FSM pops one, so exactly 1 overflow pulse (event 06 dropped), and ev_ready is low while full. After releasing dout_ready, bytes 01,02,03,04,05 arrive in order.
5. Malformed events: make with keyCode=9'h0F0 → bad_code pulse, no bytes. make=brakk=1 with keyCode=9'h01C → bad_code pulse, no bytes. FIFO stays empty in both cases.
6. Reset mid-op: assert reset after the E0 transfer of a 9'h175 break → dout_valid=0 and busy=0 immediately. After deassertion, make 9'h01C yields a lone 1C with no stale F0 or 75.

Source files
------------

// File: rtl/scancode_tx_if.sv
// Byte-stream link between the scan-code encoder and its sink.
//   dout        byte presented by the producer
//   dout_valid  dout holds a valid byte
//   dout_ready  sink accepts the byte; transfer when dout_valid && dout_ready
// master: encoder side (drives dout/dout_valid). slave: sink side (drives dout_ready).
interface scancode_tx_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/scancode_tx.sv
// Key-event to PS/2 Set-2 byte-stream encoder.
// Key events (9-bit code + make/break pulse) are queued in a small FIFO. A sequencer then
// emits E0 / F0 prefixes and the code byte over a valid/ready byte stream.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   keyCode[8:0]        [8] extended flag, [7:0] scan code
//   make, brakk         one-cycle key-press / key-release requests
//   ev_ready            FIFO not full (combinational)
//   tx                  byte stream (dout, dout_valid registered; dout_ready in)
//   busy                sequencer active or FIFO non-empty
//   overflow            pulse: valid event dropped because the FIFO was full
//   bad_code            pulse: malformed event rejected
module scancode_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8:0]          keyCode,
  input  logic                make,
  input  logic                brakk,
  output logic                ev_ready,
  scancode_tx_if.master       tx,
  output logic                busy,
  output logic                overflow,
  output logic                bad_code
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StSendE0, StSendF0, StSendCode, StGap} state_e;

  // ---------------------------------------------------------------- event FIFO
  // Entry layout: {is_break, ext, code}
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        full, empty, code_ok, ev_req, push, pop;
  logic [9:0]  head;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign ev_ready = !full;
  assign head     = mem_q[rd_q[AW-1:0]];

  assign code_ok = (keyCode[7:0] != 8'd0) && (keyCode[7:0] <= 8'd131);
  assign ev_req  = make ^ brakk;
  assign push    = ev_req && code_ok && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {brakk, keyCode};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      overflow <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      overflow <= ev_req && code_ok && full;
      bad_code <= (make && brakk) || (ev_req && !code_ok);
    end
  end

  // ---------------------------------------------------------------- sequencer
  state_e          state_q, state_d;
  logic [8:0]      hold_q, hold_d;   // {is_break, code}; ext only matters at load time
  logic [7:0]      dout_q, dout_d;
  logic            valid_q, valid_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            xfer, try_load;

  assign xfer          = valid_q && tx.dout_ready;
  assign tx.dout       = dout_q;
  assign tx.dout_valid = valid_q;
  assign busy          = (state_q != StIdle) || !empty;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    try_load = 1'b0;

    case (state_q)
      StIdle: try_load = 1'b1;
      StSendE0: begin
        if (xfer) begin
          if (hold_q[8]) begin
            dout_d  = 8'hF0;
            state_d = StSendF0;
          end else begin
            dout_d  = hold_q[7:0];
            state_d = StSendCode;
          end
        end
      end
      StSendF0: begin
        if (xfer) begin
          dout_d  = hold_q[7:0];
          state_d = StSendCode;
        end
      end
      StSendCode: begin
        if (xfer) begin
          if (GAP_CYCLES == 0) begin
            try_load = 1'b1;  // back-to-back sequences with no bubble
          end else begin
            valid_d = 1'b0;
            gap_d   = GapW'(GAP_CYCLES);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        valid_d = 1'b0;
        if (gap_q <= GapW'(1)) state_d = StIdle;
        else                   gap_d   = gap_q - 1'b1;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase

    // Pop the head and present the first byte of its sequence on the same edge.
    if (try_load) begin
      if (!empty) begin
        pop     = 1'b1;
        hold_d  = {head[9], head[7:0]};
        valid_d = 1'b1;
        if (head[8]) begin
          dout_d  = 8'hE0;
          state_d = StSendE0;
        end else if (head[9]) begin
          dout_d  = 8'hF0;
          state_d = StSendF0;
        end else begin
          dout_d  = head[7:0];
          state_d = StSendCode;
        end
      end else begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_scancode_tx.sv
// Self-checking bench for scancode_tx: directed scenarios plus randomized traffic, all compared
// every cycle against a queue-based reference model of the event FIFO and byte stream.
module tb_scancode_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] keyCode;
  logic       make, brakk;
  logic       ev_ready, busy, overflow, bad_code;

  scancode_tx_if tx();

  scancode_tx #(
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .keyCode  (keyCode),
    .make     (make),
    .brakk    (brakk),
    .ev_ready (ev_ready),
    .tx       (tx.master),
    .busy     (busy),
    .overflow (overflow),
    .bad_code (bad_code)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL [%s] %s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [9:0] m_fifo[$];   // queued events {is_break, ext, code}
  logic [7:0] m_cur[$];    // bytes of the sequence in flight; head is on dout
  int         m_gap;       // idle cycles left after a finished sequence
  bit         m_ovf, m_bad;

  logic [7:0] xfers[$];    // bytes actually transferred by the DUT
  int         ovf_seen, bad_seen;

  task automatic model_reset();
    m_fifo.delete();
    m_cur.delete();
    m_gap = 0;
    m_ovf = 0;
    m_bad = 0;
  endtask

  task automatic model_load(input logic [9:0] e);
    if (e[8]) m_cur.push_back(8'hE0);
    if (e[9]) m_cur.push_back(8'hF0);
    m_cur.push_back(e[7:0]);
  endtask

  task automatic model_edge(input logic mk, input logic bk, input logic [8:0] kc,
                            input logic rdy);
    bit pre_full, ev, ok;
    pre_full = (m_fifo.size() == DEPTH);
    ev       = mk ^ bk;
    ok       = (kc[7:0] >= 8'd1) && (kc[7:0] <= 8'd131);
    m_bad    = (mk && bk) || (ev && !ok);
    m_ovf    = ev && ok && pre_full;
    if (m_cur.size() > 0) begin
      if (rdy) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0) begin
          if (GAP > 0)                m_gap = GAP;
          else if (m_fifo.size() > 0) model_load(m_fifo.pop_front());
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_fifo.size() > 0) begin
      model_load(m_fifo.pop_front());
    end
    if (ev && ok && !pre_full) m_fifo.push_back({bk, kc});
  endtask

  task automatic compare_all();
    check("dout_valid", tx.dout_valid, m_cur.size() > 0);
    if (m_cur.size() > 0) check("dout", tx.dout, m_cur[0]);
    check("busy", busy, (m_cur.size() > 0) || (m_gap > 0) || (m_fifo.size() > 0));
    check("ev_ready", ev_ready, m_fifo.size() < DEPTH);
    check("overflow", overflow, m_ovf);
    check("bad_code", bad_code, m_bad);
  endtask

  // One clock: drive inputs, advance DUT and model on the edge, compare 1ns later.
  task automatic cycle(input logic mk, input logic bk, input logic [8:0] kc, input logic rdy);
    make          = mk;
    brakk         = bk;
    keyCode       = kc;
    tx.dout_ready = rdy;
    if (tx.dout_valid && rdy) xfers.push_back(tx.dout);
    @(posedge clk);
    model_edge(mk, bk, kc, rdy);
    #1;
    compare_all();
    if (overflow) ovf_seen++;
    if (bad_code) bad_seen++;
    make  = 1'b0;
    brakk = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'h000, rdy);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic reset_mid();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_dout", tx.dout, 8'h00);
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic clear_log();
    xfers.delete();
    ovf_seen = 0;
    bad_seen = 0;
  endtask

  initial begin
    reset         = 1'b1;
    make          = 1'b0;
    brakk         = 1'b0;
    keyCode       = '0;
    tx.dout_ready = 1'b0;
    model_reset();
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    compare_all();
    check("rst_dout", tx.dout, 8'h00);
    reset = 1'b0;

    // 1: normal make
    phase = "normal_make";
    clear_log();
    cycle(1'b1, 1'b0, 9'h01C, 1'b1);
    idle(6, 1'b1);
    check("n_bytes", xfers.size(), 1);
    if (xfers.size() >= 1) check("byte0", xfers[0], 8'h1C);

    // 2: extended break, first valid two edges after the request
    phase = "ext_break";
    clear_log();
    cycle(1'b0, 1'b1, 9'h175, 1'b1);
    check("lat_edge1", tx.dout_valid, 1'b0);
    cycle(1'b0, 1'b0, 9'h000, 1'b1);
    check("lat_edge2", tx.dout_valid, 1'b1);
    idle(8, 1'b1);
    check("n_bytes", xfers.size(), 3);
    if (xfers.size() == 3) begin
      check("byte0", xfers[0], 8'hE0);
      check("byte1", xfers[1], 8'hF0);
      check("byte2", xfers[2], 8'h75);
    end

    // 3: backpressure on an extended make
    phase = "backpressure";
    clear_log();
    cycle(1'b1, 1'b0, 9'h16B, 1'b0);
    idle(6, 1'b0);
    check("held_dout", tx.dout, 8'hE0);
    check("held_valid", tx.dout_valid, 1'b1);
    idle(8, 1'b1);
    check("n_bytes", xfers.size(), 2);
    if (xfers.size() == 2) begin
      check("byte0", xfers[0], 8'hE0);
      check("byte1", xfers[1], 8'h6B);
    end

    // 4: overflow with six back-to-back makes while the sink stalls
    phase = "overflow";
    clear_log();
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, 9'(i), 1'b0);
    idle(1, 1'b0);
    check("full_ev_ready", ev_ready, 1'b0);
    check("ovf_pulses", ovf_seen, 1);
    idle(30, 1'b1);
    check("n_bytes", xfers.size(), 5);
    if (xfers.size() == 5)
      for (int i = 0; i < 5; i++) check("byte_order", xfers[i], 32'(i + 1));

    // 5: malformed events
    phase = "malformed";
    clear_log();
    cycle(1'b1, 1'b0, 9'h0F0, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 1'b1, 9'h01C, 1'b1);
    idle(4, 1'b1);
    check("bad_pulses", bad_seen, 2);
    check("n_bytes", xfers.size(), 0);

    // 6: reset right after the E0 of an extended break
    phase = "reset_mid";
    clear_log();
    cycle(1'b0, 1'b1, 9'h175, 1'b1);
    cycle(1'b0, 1'b0, 9'h000, 1'b1);
    cycle(1'b0, 1'b0, 9'h000, 1'b1);
    reset_mid();
    clear_log();
    cycle(1'b1, 1'b0, 9'h01C, 1'b1);
    idle(8, 1'b1);
    check("n_bytes", xfers.size(), 1);
    if (xfers.size() >= 1) check("byte0", xfers[0], 8'h1C);

    // Randomized traffic, including boundary codes and occasional resets
    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      int         r;
      logic [7:0] c;
      logic       mk, bk, rdy;
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      mk  = 1'b0;
      bk  = 1'b0;
      c   = 8'h00;
      if (r < 35) begin
        bk = $urandom_range(0, 1) == 1;
        mk = !bk;
        case ($urandom_range(0, 5))
          0:       c = 8'd1;
          1:       c = 8'd131;
          default: c = 8'($urandom_range(1, 131));
        endcase
      end else if (r < 40) begin
        mk = 1'b1;
        c  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(132, 255));
      end else if (r < 43) begin
        mk = 1'b1;
        bk = 1'b1;
        c  = 8'($urandom_range(1, 131));
      end
      cycle(mk, bk, {1'($urandom_range(0, 1)), c}, rdy);
      if ($urandom_range(0, 399) == 0) reset_mid();
    end
    idle(40, 1'b1);
    check("drained_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
